// File: rtl/ahb_req_arbiter.sv
// Two-requester front end for a single-word AHB-Lite master.
// Round-robin selection, one outstanding transfer, fully registered bus and status outputs.
module ahb_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [1:0]            req,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [1:0]            wr,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  // Winner index; the served flag keeps requester 0 ahead on the first tie after reset.
  function automatic logic pick_winner(input logic [1:0] r, input logic served, input logic last);
    logic w;
    case (r)
      2'b01:   w = 1'b0;
      2'b10:   w = 1'b1;
      2'b11:   w = served ? ~last : 1'b0;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  state_t                state_r, state_nxt;
  logic                  sel_r, sel_nxt;
  logic                  last_r, last_nxt;
  logic                  served_r, served_nxt;
  logic                  err_flag_r, err_flag_nxt;
  logic [DATA_WIDTH-1:0] wdata_lat_r, wdata_lat_nxt;
  logic [1:0]            gnt_r, gnt_nxt;
  logic [1:0]            done_r, done_nxt;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt;
  logic                  err_r, err_nxt;
  logic [ADDR_WIDTH-1:0] haddr_r, haddr_nxt;
  logic [1:0]            htrans_r, htrans_nxt;
  logic                  hwrite_r, hwrite_nxt;
  logic [DATA_WIDTH-1:0] hwdata_r, hwdata_nxt;
  logic                  win_s;
  logic                  hresp_err_s;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_nxt     = state_r;
    sel_nxt       = sel_r;
    last_nxt      = last_r;
    served_nxt    = served_r;
    err_flag_nxt  = err_flag_r;
    wdata_lat_nxt = wdata_lat_r;
    gnt_nxt       = 2'b00;
    done_nxt      = 2'b00;
    rdata_nxt     = rdata_r;
    err_nxt       = err_r;
    haddr_nxt     = haddr_r;
    htrans_nxt    = htrans_r;
    hwrite_nxt    = hwrite_r;
    hwdata_nxt    = hwdata_r;
    win_s         = pick_winner(req, served_r, last_r);
    hresp_err_s   = (HRESP == RESP_ERROR);

    case (state_r)
      IDLE: begin
        htrans_nxt = TRANS_IDLE;
        if ((req != 2'b00) && HREADY) begin
          state_nxt     = ADDR;
          sel_nxt       = win_s;
          gnt_nxt       = win_s ? 2'b10 : 2'b01;
          haddr_nxt     = win_s ? addr1 : addr0;
          hwrite_nxt    = win_s ? wr[1] : wr[0];
          wdata_lat_nxt = win_s ? wdata1 : wdata0;
          htrans_nxt    = TRANS_NONSEQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR: begin
        if (HREADY) begin
          state_nxt    = DATA;
          htrans_nxt   = TRANS_IDLE;
          err_flag_nxt = 1'b0;
          if (hwrite_r) begin
            hwdata_nxt = wdata_lat_r;
          end else begin
            hwdata_nxt = hwdata_r;
          end
        end else begin
          state_nxt = ADDR;
        end
      end
      DATA: begin
        // The completing cycle's own response counts toward the error flag.
        err_flag_nxt = err_flag_r | hresp_err_s;
        if (HREADY) begin
          state_nxt  = IDLE;
          done_nxt   = sel_r ? 2'b10 : 2'b01;
          err_nxt    = err_flag_r | hresp_err_s;
          last_nxt   = sel_r;
          served_nxt = 1'b1;
          if (hwrite_r) begin
            rdata_nxt = rdata_r;
          end else begin
            rdata_nxt = HRDATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      default: begin
        state_nxt  = IDLE;
        htrans_nxt = TRANS_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= IDLE;
      sel_r       <= 1'b0;
      last_r      <= 1'b0;
      served_r    <= 1'b0;
      err_flag_r  <= 1'b0;
      wdata_lat_r <= '0;
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      rdata_r     <= '0;
      err_r       <= 1'b0;
      haddr_r     <= '0;
      htrans_r    <= TRANS_IDLE;
      hwrite_r    <= 1'b0;
      hwdata_r    <= '0;
    end else begin
      state_r     <= state_nxt;
      sel_r       <= sel_nxt;
      last_r      <= last_nxt;
      served_r    <= served_nxt;
      err_flag_r  <= err_flag_nxt;
      wdata_lat_r <= wdata_lat_nxt;
      gnt_r       <= gnt_nxt;
      done_r      <= done_nxt;
      rdata_r     <= rdata_nxt;
      err_r       <= err_nxt;
      haddr_r     <= haddr_nxt;
      htrans_r    <= htrans_nxt;
      hwrite_r    <= hwrite_nxt;
      hwdata_r    <= hwdata_nxt;
    end
  end

  assign gnt    = gnt_r;
  assign done   = done_r;
  assign rdata  = rdata_r;
  assign err    = err_r;
  assign HADDR  = haddr_r;
  assign HTRANS = htrans_r;
  assign HWRITE = hwrite_r;
  assign HSIZE  = SIZE_WORD;
  assign HWDATA = hwdata_r;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed self-checking bench for ahb_req_arbiter.
module tb_ahb_req_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  req;
  logic [31:0] addr0, addr1;
  logic [1:0]  wr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  gnt, done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  int total = 0;
  int bad   = 0;

  ahb_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req(req), .addr0(addr0), .addr1(addr1),
    .wr(wr), .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; req = 2'b00; wr = 2'b00; addr0 = 32'h0; addr1 = 32'h0;
    wdata0 = 32'h0; wdata1 = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 2'b00;
    tick(); tick();
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%h exp=00", HTRANS); end
    total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
    total++; if (HWRITE !== 1'b0) begin bad++; $display("FAIL rst_hwrite got=%b exp=0", HWRITE); end
    total++; if (HSIZE !== 3'b010) begin bad++; $display("FAIL rst_hsize got=%b exp=010", HSIZE); end
    total++; if (HWDATA !== 32'h0) begin bad++; $display("FAIL rst_hwdata got=%h exp=0", HWDATA); end
    total++; if (gnt !== 2'b00 || done !== 2'b00) begin bad++; $display("FAIL rst_pulses gnt=%b done=%b exp=00", gnt, done); end
    total++; if (rdata !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL rst_status rdata=%h err=%b exp=0", rdata, err); end
    HRESET = 1'b0;
  endtask

  task automatic test_write0();
    req = 2'b01; wr = 2'b01; addr0 = 32'h0000_1000; wdata0 = 32'hDEAD_BEEF; HREADY = 1'b1;
    tick();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
    total++; if (HADDR !== 32'h0000_1000) begin bad++; $display("FAIL wr_haddr got=%h exp=1000", HADDR); end
    total++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1) begin bad++; $display("FAIL wr_ctrl htrans=%b hwrite=%b exp=10/1", HTRANS, HWRITE); end
    req = 2'b00; addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0; wr = 2'b00;
    tick();
    total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL wr_data_htrans got=%b exp=00", HTRANS); end
    total++; if (HWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hwdata got=%h exp=deadbeef", HWDATA); end
    total++; if (gnt !== 2'b00 || done !== 2'b00) begin bad++; $display("FAIL wr_mid gnt=%b done=%b exp=00/00", gnt, done); end
    tick();
    total++; if (done !== 2'b01 || err !== 1'b0) begin bad++; $display("FAIL wr_done done=%b err=%b exp=01/0", done, err); end
    tick();
    total++; if (done !== 2'b00) begin bad++; $display("FAIL wr_done_pulse got=%b exp=00", done); end
    total++; if (HADDR !== 32'h0000_1000 || HWRITE !== 1'b1) begin bad++; $display("FAIL idle_hold haddr=%h hwrite=%b exp=1000/1", HADDR, HWRITE); end
  endtask

  task automatic test_read1_wait();
    req = 2'b10; wr = 2'b00; addr1 = 32'h0000_2000; HREADY = 1'b1;
    tick();
    total++; if (gnt !== 2'b10 || HADDR !== 32'h0000_2000 || HWRITE !== 1'b0) begin bad++; $display("FAIL rd_gnt gnt=%b haddr=%h hwrite=%b exp=10/2000/0", gnt, HADDR, HWRITE); end
    req = 2'b00;
    tick();
    total++; if (HWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hwdata_hold got=%h exp=deadbeef", HWDATA); end
    HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (done !== 2'b00) begin bad++; $display("FAIL rd_wait_done cyc=%0d got=%b exp=00", i, done); end
    end
    HRDATA = 32'h1234_5678; HREADY = 1'b1;
    tick();
    total++; if (done !== 2'b10) begin bad++; $display("FAIL rd_done got=%b exp=10", done); end
    total++; if (rdata !== 32'h1234_5678 || err !== 1'b0) begin bad++; $display("FAIL rd_data rdata=%h err=%b exp=12345678/0", rdata, err); end
    HRDATA = 32'h0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    int n;
    HRESET = 1'b1; tick(); HRESET = 1'b0;
    req = 2'b11; wr = 2'b00; HREADY = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      tick();
      if (gnt != 2'b00) begin
        order[n] = gnt;
        n++;
      end
    end
    req = 2'b00;
    total++; if (n != 4) begin bad++; $display("FAIL rr_timeout grants=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      total++;
      if (order[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_order idx=%0d got=%b exp=%b", k, order[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    tick(); tick(); tick();
  endtask

  task automatic test_error();
    req = 2'b01; wr = 2'b00; addr0 = 32'h0000_3000; HREADY = 1'b1;
    tick(); req = 2'b00;
    tick();
    HRESP = 2'b01; HREADY = 1'b0;
    tick();
    total++; if (done !== 2'b00) begin bad++; $display("FAIL err_wait_done got=%b exp=00", done); end
    HREADY = 1'b1;
    tick();
    total++; if (done !== 2'b01 || err !== 1'b1) begin bad++; $display("FAIL err_done done=%b err=%b exp=01/1", done, err); end
    HRESP = 2'b00;
    tick();
    req = 2'b01;
    tick(); req = 2'b00;
    tick(); tick();
    total++; if (done !== 2'b01 || err !== 1'b0) begin bad++; $display("FAIL err_clear done=%b err=%b exp=01/0", done, err); end
    tick();
  endtask

  task automatic test_reset_in_data();
    req = 2'b01; wr = 2'b01; addr0 = 32'h0000_4000; wdata0 = 32'hA5A5_A5A5; HREADY = 1'b1;
    tick(); req = 2'b00;
    tick(); HREADY = 1'b0;
    tick();
    req = 2'b10; addr1 = 32'h0000_5000; wr = 2'b00;
    HRESET = 1'b1;
    #1;
    total++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      bad++; $display("FAIL async_rst htrans=%b haddr=%h hwrite=%b hwdata=%h exp=0", HTRANS, HADDR, HWRITE, HWDATA);
    end
    total++; if (done !== 2'b00 || gnt !== 2'b00 || err !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL async_rst_status done=%b gnt=%b err=%b rdata=%h exp=0", done, gnt, err, rdata);
    end
    HREADY = 1'b1;
    tick();
    total++; if (done !== 2'b00) begin bad++; $display("FAIL rst_no_done got=%b exp=00", done); end
    HRESET = 1'b0;
    tick();
    total++; if (gnt !== 2'b10 || HADDR !== 32'h0000_5000 || done !== 2'b00) begin
      bad++; $display("FAIL post_rst_gnt gnt=%b haddr=%h done=%b exp=10/5000/00", gnt, HADDR, done);
    end
    req = 2'b00;
    tick(); tick();
    total++; if (done !== 2'b10) begin bad++; $display("FAIL post_rst_done got=%b exp=10", done); end
  endtask

  initial begin
    test_reset();
    test_write0();
    test_read1_wait();
    test_round_robin();
    test_error();
    test_reset_in_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_req_arbiter.md
AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 Parameters SHALL be:
  ADDR_WIDTH  32  address width
  DATA_WIDTH  32  data width
REQ-002 Ports SHALL be:
  HCLK       in   1      bus clock, all state on rising edge
  HRESET     in   1      asynchronous, active-high reset
  req        in   2      per-requester transfer request, bit i = requester i
  addr0      in   AW     requester 0 address
  addr1      in   AW     requester 1 address
  wr         in   2      per-requester direction, 1 = write
  wdata0     in   DW     requester 0 write data
  wdata1     in   DW     requester 1 write data
  gnt        out  2      one-cycle pulse, command of requester i accepted
  done       out  2      one-cycle pulse, transfer of requester i complete
  rdata      out  DW     read data of the last completed transfer
  err        out  1      error flag of the last completed transfer, valid with done
  HADDR      out  AW     AHB address
  HTRANS     out  2      AHB transfer type
  HWRITE     out  1      AHB direction
  HSIZE      out  3      AHB size
  HWDATA     out  DW     AHB write data
  HRDATA     in   DW     AHB read data
  HREADY     in   1      AHB ready
  HRESP      in   2      AHB response
REQ-003 All outputs SHALL be registered.

Function
REQ-004 FSM states SHALL be IDLE, ADDR and DATA; only single word transfers, with HSIZE=3'b010 at all times and HTRANS limited to IDLE(00) and NONSEQ(10).
REQ-005 IDLE with req!=0 and HREADY=1 SHALL select one requester at the clock edge and move to ADDR.
REQ-006 Selection: a single active request wins; if both are active, the requester not served last wins (round-robin); after reset requester 0 has priority.
REQ-007 On the selecting edge, the block SHALL latch the winner's addr, wr and wdata, drive HADDR, HWRITE and HTRANS=NONSEQ, and pulse gnt[i] for one cycle; requester i may change or drop its inputs from the next cycle.
REQ-008 In ADDR, HREADY=1 at an edge SHALL move to DATA with HTRANS=IDLE and HWDATA set to the latched wdata (writes only; HWDATA holds on reads); HREADY=0 SHALL hold all address-phase outputs.
REQ-009 In DATA, any cycle with HRESP==2'b01 SHALL set an internal error flag; HREADY=1 at an edge SHALL complete the transfer.
REQ-010 On completion the block SHALL pulse done[i] for one cycle, load rdata from HRDATA (reads only; rdata holds on writes), set err = the error flag, update the last-served pointer to i, and return to IDLE.
REQ-011 Minimum latency SHALL be: req at edge k, gnt and NONSEQ after k, DATA after k+1, done after k+2 with zero wait states; one transfer is outstanding at most (no address/data overlap).
REQ-012 A request arriving while not in IDLE SHALL wait and is never dropped while req stays high.
REQ-013 HADDR and HWRITE SHALL hold their last values in IDLE.

Reset
REQ-014 While HRESET=1 the block SHALL immediately set: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, gnt=0, done=0, rdata=0, err=0, pointer=requester 0.
REQ-015 Reset during ADDR or DATA SHALL abandon the transfer with no done pulse.

Verification
REQ-016 Write through requester 0: req=01, addr0=0x1000, wdata0=0xDEADBEEF, HREADY=1 -> gnt=01, HADDR=0x1000, HTRANS=10, HWRITE=1, then HWDATA=0xDEADBEEF, done=01 three cycles after req.
REQ-017 Read through requester 1 with two wait states in DATA, HRDATA=0x12345678 -> done=10 only after HREADY returns high, rdata=0x12345678, err=0.
REQ-018 req=11 held for four transfers from reset -> grant order 0,1,0,1.
REQ-019 HRESP=01 for two cycles in DATA (HREADY 0 then 1) -> done pulses with err=1; the next clean transfer returns err=0.
REQ-020 HRESET asserted in the DATA state -> outputs at reset values asynchronously, no done; after release, a pending req=10 is granted to requester 1.
